// File: rtl/seg_scan_driver_if.sv
// Display-side bus of the six-digit scan driver: the packed-BCD input and the
// registered anode/segment/decimal-point outputs together with the frame pulse.
interface seg_scan_driver_if;
    logic [23:0] digit;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    modport master (output digit, input an, seg, dp, frame_tick);
    modport slave  (input digit, output an, seg, dp, frame_tick);
endinterface

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed common-anode seven-segment driver with per-frame
// snapshot, guard interval, BCD decode and leading-zero blanking.
module seg_scan_driver #(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned GUARD = 16,
    parameter bit          LZB   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_driver_if.slave  bus
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [23:0]   shadow_q, shadow_d;
    logic [5:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_tick_q, frame_tick_d;

    logic          slot_end;
    logic          capture;
    logic          lit;
    logic          blank;
    logic [3:0]    nib;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end = (cnt_q == CNT_MAX);
        capture  = slot_end && (idx_q == 3'd5);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
        // The snapshot only moves at a frame boundary so a frame never mixes two values.
        shadow_d     = capture ? bus.digit : shadow_q;
        frame_tick_d = capture;

        case (idx_q)
            3'd0:    nib = shadow_q[23:20];
            3'd1:    nib = shadow_q[19:16];
            3'd2:    nib = shadow_q[15:12];
            3'd3:    nib = shadow_q[11:8];
            3'd4:    nib = shadow_q[7:4];
            default: nib = shadow_q[3:0];
        endcase

        // PC and data fields blank independently; the units digit of each is always shown.
        case (idx_q)
            3'd0:    blank = (shadow_q[23:20] == 4'd0);
            3'd2:    blank = (shadow_q[15:12] == 4'd0);
            3'd3:    blank = (shadow_q[15:8] == 8'd0);
            3'd4:    blank = (shadow_q[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase
        blank = blank && LZB;

        lit  = (cnt_q >= GUARD_C);
        an_d = 6'b111111;
        seg_d = 7'b1111111;
        dp_d = 1'b1;
        if (lit) begin
            an_d  = ~(6'b100000 >> idx_q);
            seg_d = blank ? 7'b1111111 : decode(nib);
            dp_d  = (idx_q != 3'd1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            shadow_q     <= 24'd0;
            an_q         <= 6'b111111;
            seg_q        <= 7'b1111111;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: two instances (blanking off and on)
// share one digit bus and are compared cycle by cycle against a reference model.
module tb_seg_scan_driver;

    localparam int DIV   = 8;
    localparam int GUARD = 2;
    localparam int FRAME = 6 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] dig = 24'h123456;

    int total = 0;
    int bad   = 0;

    seg_scan_driver_if bus0 ();
    seg_scan_driver_if bus1 ();
    assign bus0.digit = dig;
    assign bus1.digit = dig;

    seg_scan_driver #(.DIV(DIV), .GUARD(GUARD), .LZB(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    seg_scan_driver #(.DIV(DIV), .GUARD(GUARD), .LZB(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] an;
        logic [6:0] seg0;
        logic [6:0] seg1;
        logic       dp;
        logic       ft;
    } exp_t;

    exp_t sbq[$];

    int          mcnt   = 0;
    int          midx   = 0;
    logic [23:0] msh    = 24'd0;
    int          ecount = 0;

    // Reference segment patterns, {g..a} active-low.
    function automatic logic [6:0] segOf(input logic [3:0] n);
        logic [6:0] t [10];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        if (n > 4'd9) return 7'b0111111;
        return t[n];
    endfunction

    function automatic logic isBlank(input int k, input logic [23:0] sh);
        logic z;
        if (k == 0) return (sh[23:20] == 4'd0);
        if (k < 2 || k > 4) return 1'b0;
        z = 1'b1;
        for (int j = 2; j <= k; j++) begin
            if (sh[23-4*j -: 4] != 4'd0) z = 1'b0;
        end
        return z;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference model: each active edge predicts the registered outputs it produces.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcnt = 0;
            midx = 0;
            msh = 24'd0;
            ecount = 0;
            sbq.delete();
        end else begin
            exp_t e;
            logic [3:0] n;
            logic lt;
            lt = (mcnt >= GUARD);
            n = msh[23-4*midx -: 4];
            e.an = 6'b111111;
            e.seg0 = 7'b1111111;
            e.seg1 = 7'b1111111;
            e.dp = 1'b1;
            if (lt) begin
                e.an[5-midx] = 1'b0;
                e.seg0 = segOf(n);
                e.seg1 = isBlank(midx, msh) ? 7'b1111111 : segOf(n);
                e.dp = (midx != 1);
            end
            e.ft = (midx == 5) && (mcnt == DIV - 1);
            sbq.push_back(e);
            ecount++;
            if (mcnt == DIV - 1) begin
                mcnt = 0;
                if (midx == 5) begin
                    midx = 0;
                    msh = dig;
                end else begin
                    midx++;
                end
            end else begin
                mcnt++;
            end
        end
    end

    logic [5:0] prevAn   = 6'b111111;
    int         offRun   = 0;
    int         onRun    = 0;
    bit         seenLit  = 0;
    bit         firstAn  = 0;
    bit         firstFt  = 0;

    // Output comparison plus anode-overlap, guard and lit-length tracking.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            checkOutput("rst_an0", bus0.an, 6'b111111);
            checkOutput("rst_an1", bus1.an, 6'b111111);
            checkOutput("rst_seg1", bus1.seg, 7'b1111111);
            checkOutput("rst_dp1", bus1.dp, 1'b1);
            checkOutput("rst_ft1", bus1.frame_tick, 1'b0);
            prevAn = 6'b111111;
            offRun = 0;
            onRun = 0;
            seenLit = 0;
            firstAn = 0;
            firstFt = 0;
        end else if (sbq.size() > 0) begin
            exp_t e;
            logic [5:0] a;
            e = sbq.pop_front();
            checkOutput("an0", bus0.an, e.an);
            checkOutput("an1", bus1.an, e.an);
            checkOutput("seg0", bus0.seg, e.seg0);
            checkOutput("seg1", bus1.seg, e.seg1);
            checkOutput("dp0", bus0.dp, e.dp);
            checkOutput("dp1", bus1.dp, e.dp);
            checkOutput("ft0", bus0.frame_tick, e.ft);
            checkOutput("ft1", bus1.frame_tick, e.ft);

            a = bus1.an;
            checkOutput("onehot", ($countones(~a) <= 1), 1'b1);
            if (!firstAn && a != 6'b111111) begin
                checkOutput("first_an_cycle", ecount, GUARD + 1);
                firstAn = 1;
            end
            if (!firstFt && bus1.frame_tick) begin
                checkOutput("first_tick_cycle", ecount, FRAME);
                firstFt = 1;
            end
            if (a == 6'b111111) begin
                if (prevAn != 6'b111111) checkOutput("lit_len", onRun, DIV - GUARD);
                offRun++;
            end else if (prevAn == 6'b111111) begin
                if (seenLit) checkOutput("guard_len", (offRun >= GUARD), 1'b1);
                offRun = 0;
                onRun = 1;
                seenLit = 1;
            end else if (a == prevAn) begin
                onRun++;
            end else begin
                checkOutput("overlap", a, prevAn);
            end
            prevAn = a;
        end
    end

    task automatic applyStimulus(input logic [23:0] d, input int cycles);
        @(negedge clk);
        #1 dig = d;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic waitFrameTick();
        bit hit;
        hit = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (bus1.frame_tick === 1'b1) begin
                hit = 1;
                break;
            end
        end
        if (!hit) checkOutput("tick_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;

        applyStimulus(24'h123456, 3 * FRAME);
        applyStimulus(24'h050007, 3 * FRAME);
        applyStimulus(24'h000000, 2 * FRAME);

        applyStimulus(24'h111111, 0);
        waitFrameTick();
        repeat (3 * DIV + 3) @(negedge clk);
        applyStimulus(24'h999999, 2 * FRAME);

        applyStimulus(24'hAF0C0B, 3 * FRAME);

        begin
            bit lit;
            lit = 0;
            for (int i = 0; i < 2 * DIV; i++) begin
                @(negedge clk);
                if (bus1.an != 6'b111111) begin
                    lit = 1;
                    break;
                end
            end
            if (!lit) checkOutput("lit_timeout", 1'b0, 1'b1);
        end
        #1 rst = 1'b0;
        #1;
        checkOutput("async_an1", bus1.an, 6'b111111);
        checkOutput("async_seg1", bus1.seg, 7'b1111111);
        checkOutput("async_dp1", bus1.dp, 1'b1);
        checkOutput("async_an0", bus0.an, 6'b111111);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        repeat (2 * FRAME) @(negedge clk);

        for (int i = 0; i < 20 * FRAME; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                #1 dig = 24'($urandom);
            end
        end

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
